// File: rtl/dm_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader port, the arbiter and the data memory.
// The slave modport is the arbiter's view. The master modport is the view of the clients and memory.
interface dm_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_ready;

    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready,
        output dm_we, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready,
        input  dm_we, dm_addr, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Single-port data memory arbiter. cpu has fixed priority, and dbg has a bounded wait.
// Partial cpu stores are done as a two-cycle read-modify-write.
module dm_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {IDLE, MERGE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   streak_reg, streak_next;
    logic [31:0]        merge_reg, merge_next;

    logic [31:0]        merge_data;
    logic [31:0]        cpu_word_addr;
    logic [31:0]        dbg_word_addr;
    logic               dbg_sel;
    logic               dbg_grant;
    logic               cpu_done;
    logic               unused_bits;

    assign cpu_word_addr = {bus.cpu_addr[31:2], 2'b00};
    assign dbg_word_addr = {bus.dbg_addr[31:2], 2'b00};
    assign unused_bits   = &{1'b0, bus.cpu_addr[1:0], bus.dbg_addr[1:0]};

    // Enabled lanes take the store data, and the other lanes keep the current memory word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merge_data[8*gi +: 8] = bus.cpu_be[gi] ? bus.cpu_wdata[8*gi +: 8]
                                                          : bus.dm_rdata[8*gi +: 8];
        end
    endgenerate

    assign dbg_sel = bus.dbg_req &
                     (~bus.cpu_req | (streak_reg == CNT_W'(STARVE_LIMIT)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            streak_reg <= '0;
            merge_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
            merge_reg  <= merge_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        merge_next    = merge_reg;
        dbg_grant     = 1'b0;
        cpu_done      = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = '0;
        bus.dbg_ready = 1'b0;
        bus.dbg_rdata = '0;

        // While reset is held, all outputs stay quiet. A pending merge is dropped by the state register.
        if (reset) begin
            unique case (state_reg)
                IDLE: begin
                    if (dbg_sel) begin
                        dbg_grant     = 1'b1;
                        bus.dm_addr   = dbg_word_addr;
                        bus.dbg_rdata = bus.dm_rdata;
                        bus.dbg_ready = 1'b1;
                        if (bus.dbg_we) begin
                            bus.dm_we    = 1'b1;
                            bus.dm_wdata = bus.dbg_wdata;
                        end
                    end else if (bus.cpu_req) begin
                        bus.dm_addr   = cpu_word_addr;
                        bus.cpu_rdata = bus.dm_rdata;
                        if (!bus.cpu_we || bus.cpu_be == 4'h0) begin
                            bus.cpu_ready = 1'b1;
                            cpu_done      = 1'b1;
                        end else if (bus.cpu_be == 4'hF) begin
                            bus.dm_we     = 1'b1;
                            bus.dm_wdata  = bus.cpu_wdata;
                            bus.cpu_ready = 1'b1;
                            cpu_done      = 1'b1;
                        end else begin
                            merge_next = merge_data;
                            state_next = MERGE;
                        end
                    end
                end
                MERGE: begin
                    bus.dm_addr   = cpu_word_addr;
                    bus.dm_we     = 1'b1;
                    bus.dm_wdata  = merge_reg;
                    bus.cpu_rdata = bus.dm_rdata;
                    bus.cpu_ready = 1'b1;
                    cpu_done      = 1'b1;
                    state_next    = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The streak counts only completed cpu accesses that happen while dbg is waiting.
    always_comb begin
        streak_next = streak_reg;
        if (dbg_grant || !bus.dbg_req)
            streak_next = '0;
        else if (cpu_done && streak_reg != CNT_W'(STARVE_LIMIT))
            streak_next = streak_reg + CNT_W'(1);
    end
endmodule
